// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, terminal-count flags and registered
// overflow/underflow pulses. Embedded concurrent checks cover the counting rules.
module updown_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned STEP     = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);

  if (WIDTH < 2 || STEP == 0 || STEP > MAX_VAL || MAX_VAL > (2**WIDTH) - 1) begin : g_param_check
    $error("updown_counter_param: illegal WIDTH/MAX_VAL/STEP combination");
  end

  // One extra bit so sums and wrap corrections never truncate.
  localparam logic [WIDTH:0]   MaxExt  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   StepExt = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ModExt  = MaxExt + 1'b1;
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   wrap_up_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   wrap_dn_ext;
  logic             up_limit;
  logic             dn_limit;
  logic [WIDTH-1:0] load_clamp;

  always_comb begin
    cnt_ext     = {1'b0, count_q};
    sum_ext     = cnt_ext + StepExt;
    wrap_up_ext = sum_ext - ModExt;
    diff_ext    = cnt_ext - StepExt;
    wrap_dn_ext = cnt_ext + ModExt - StepExt;
    up_limit    = sum_ext > MaxExt;
    dn_limit    = cnt_ext < StepExt;
    load_clamp  = ({1'b0, load_val} > MaxExt) ? MaxVal : load_val;

    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (load) begin
      count_d = load_clamp;
    end else if (en) begin
      if (up_down) begin
        ovf_d = up_limit;
        if (!up_limit)     count_d = sum_ext[WIDTH-1:0];
        else if (SATURATE) count_d = MaxVal;
        else               count_d = wrap_up_ext[WIDTH-1:0];
      end else begin
        unf_d = dn_limit;
        if (!dn_limit)     count_d = diff_ext[WIDTH-1:0];
        else if (SATURATE) count_d = '0;
        else               count_d = wrap_dn_ext[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count  = count_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (count_q == MaxVal);
  assign at_min = (count_q == '0);

  // Checker reference written in plain integer arithmetic, independent of the datapath above.
  function automatic int exp_up(int c);
    if (c + STEP > MAX_VAL) return SATURATE ? MAX_VAL : c + STEP - MAX_VAL - 1;
    return c + STEP;
  endfunction

  function automatic int exp_down(int c);
    if (c < STEP) return SATURATE ? 0 : c + MAX_VAL + 1 - STEP;
    return c - STEP;
  endfunction

  function automatic int exp_load(int v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  a_up: assert property (@(posedge clk) disable iff (reset)
    en && !load && up_down |=> int'(count) == exp_up(int'($past(count))));

  a_down: assert property (@(posedge clk) disable iff (reset)
    en && !load && !up_down |=> int'(count) == exp_down(int'($past(count))));

  a_load: assert property (@(posedge clk) disable iff (reset)
    load |=> int'(count) == exp_load(int'($past(load_val))));

  a_hold: assert property (@(posedge clk) disable iff (reset)
    !en && !load |=> $stable(count));

  a_range: assert property (@(posedge clk) disable iff (reset)
    int'(count) <= MAX_VAL);

  a_excl: assert property (@(posedge clk) disable iff (reset)
    !(ovf && unf));

  a_reset: assert property (@(posedge clk) reset |=> count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations (MAX_VAL=9) driven in parallel,
// compared every cycle against an integer reference model plus directed literal checks.
module tb_updown_counter_param;

  localparam int MX = 9;
  localparam int CfgStep [3] = '{1, 3, 3};
  localparam bit CfgSat  [3] = '{1'b0, 1'b0, 1'b1};

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_down;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] d_cnt [3];
  logic       d_max [3];
  logic       d_min [3];
  logic       d_ovf [3];
  logic       d_unf [3];

  int m_cnt [3];
  bit m_ovf [3];
  bit m_unf [3];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b0;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(1'b0)) u_wrap1 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(d_cnt[0]), .at_max(d_max[0]), .at_min(d_min[0]), .ovf(d_ovf[0]), .unf(d_unf[0])
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(1'b0)) u_wrap3 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(d_cnt[1]), .at_max(d_max[1]), .at_min(d_min[1]), .ovf(d_ovf[1]), .unf(d_unf[1])
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(1'b1)) u_sat3 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .count(d_cnt[2]), .at_max(d_max[2]), .at_min(d_min[2]), .ovf(d_ovf[2]), .unf(d_unf[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int up_next(int c, int st, bit sat);
    if (c + st <= MX) return c + st;
    return sat ? MX : c + st - (MX + 1);
  endfunction

  function automatic int down_next(int c, int st, bit sat);
    if (c - st >= 0) return c - st;
    return sat ? 0 : c - st + (MX + 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i] <= 0;
        m_ovf[i] <= 1'b0;
        m_unf[i] <= 1'b0;
      end else if (load) begin
        m_cnt[i] <= (int'(load_val) > MX) ? MX : int'(load_val);
        m_ovf[i] <= 1'b0;
        m_unf[i] <= 1'b0;
      end else if (en && up_down) begin
        m_cnt[i] <= up_next(m_cnt[i], CfgStep[i], CfgSat[i]);
        m_ovf[i] <= (m_cnt[i] + CfgStep[i] > MX);
        m_unf[i] <= 1'b0;
      end else if (en) begin
        m_cnt[i] <= down_next(m_cnt[i], CfgStep[i], CfgSat[i]);
        m_ovf[i] <= 1'b0;
        m_unf[i] <= (m_cnt[i] < CfgStep[i]);
      end else begin
        m_ovf[i] <= 1'b0;
        m_unf[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cfg%0d count", i), int'(d_cnt[i]), m_cnt[i]);
        check($sformatf("cfg%0d ovf", i), int'(d_ovf[i]), int'(m_ovf[i]));
        check($sformatf("cfg%0d unf", i), int'(d_unf[i]), int'(m_unf[i]));
        check($sformatf("cfg%0d at_max", i), int'(d_max[i]), int'(m_cnt[i] == MX));
        check($sformatf("cfg%0d at_min", i), int'(d_min[i]), int'(m_cnt[i] == 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectations, applied to both the DUT and the reference model.
  task automatic lit(input int i, input string name, input int c, input int o, input int u);
    check($sformatf("%s cfg%0d count", name, i), int'(d_cnt[i]), c);
    check($sformatf("%s cfg%0d ovf", name, i), int'(d_ovf[i]), o);
    check($sformatf("%s cfg%0d unf", name, i), int'(d_unf[i]), u);
    check($sformatf("%s model%0d count", name, i), m_cnt[i], c);
    check($sformatf("%s model%0d ovf", name, i), int'(m_ovf[i]), o);
    check($sformatf("%s model%0d unf", name, i), int'(m_unf[i]), u);
  endtask

  task automatic do_load(input int v);
    load     = 1'b1;
    en       = 1'b0;
    load_val = 4'(v);
    tick();
    load     = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    up_down  = 1'b1;
    load     = 1'b0;
    load_val = '0;

    // Reset held with counting requested
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp_on = 1'b1;
      lit(0, "reset", 0, 0, 0);
      check("reset at_min", int'(d_min[0]), 1);
      check("reset at_max", int'(d_max[0]), 0);
    end

    // Wrap up through 9 -> 0 with STEP=1
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      lit(0, $sformatf("wrap_up k=%0d", k), k % 10, int'(k == 10), 0);
    end

    // STEP=3 wrap in both directions
    do_load(8);
    lit(1, "load8", 8, 0, 0);
    en = 1'b1; up_down = 1'b1;
    tick();
    lit(1, "step_up_wrap", 1, 1, 0);
    up_down = 1'b0;
    tick();
    lit(1, "step_dn_wrap", 8, 0, 1);

    // STEP=3 saturate
    do_load(2);
    lit(2, "load2", 2, 0, 0);
    en = 1'b1; up_down = 1'b0;
    tick();
    lit(2, "sat_dn_from2", 0, 0, 1);
    tick();
    lit(2, "sat_dn_from0", 0, 0, 1);
    do_load(9);
    en = 1'b1; up_down = 1'b1;
    tick();
    lit(2, "sat_up_from9", 9, 1, 0);
    do_load(6);
    en = 1'b1; up_down = 1'b1;
    tick();
    lit(2, "sat_up_from6", 9, 0, 0);

    // Load beats enable and clamps to MAX_VAL
    load = 1'b1; en = 1'b1; up_down = 1'b1; load_val = 4'd12;
    tick();
    for (int i = 0; i < 3; i++) lit(i, "load12", 9, 0, 0);
    check("load12 at_max", int'(d_max[0]), 1);
    load = 1'b0; en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      lit(0, "hold", 9, 0, 0);
    end

    // Reset mid-count
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    lit(0, "pre_reset", 5, 0, 0);
    reset = 1'b1;
    tick();
    lit(0, "mid_reset", 0, 0, 0);
    reset = 1'b0;

    // Random traffic, checked every cycle by the compare process
    for (int k = 0; k < 200; k++) begin
      reset    = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_down  = $urandom_range(0, 1) == 1;
      load_val = 4'($urandom_range(0, 15));
      tick();
    end
    reset = 1'b0; load = 1'b0; en = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
